// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Purpose : UART receive buffer; acks bytes from the rx engine into a
//           first-word-fall-through circular FIFO for the processor.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxrdy,
  input  logic [7:0]    rx_data,
  input  logic [2:0]    rx_err,
  output logic          rx_ack,
  input  logic          rd,
  input  logic          clr,
  output logic [7:0]    dout,
  output logic [2:0]    dout_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf_sticky,
  output logic          ne_pulse
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic [10:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_rx_ack;
  logic            r_ovf_sticky;
  logic            r_ne_pulse;

  logic            w_empty;
  logic            w_full;
  logic            w_capture;
  logic            w_wr;
  logic            w_rd;
  logic            w_ovf;
  logic [10:0]     w_head;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_capture = (r_state == S_IDLE) && rxrdy && !w_full;
  // A flush drops the byte being captured but the handshake still completes.
  assign w_wr      = w_capture && !clr;
  assign w_rd      = rd && !w_empty && !clr;
  assign w_ovf     = (r_state == S_IDLE) && rxrdy && w_full;
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {rx_err, rx_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rx_ack     <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_ne_pulse   <= 1'b0;
    end else begin
      r_rx_ack   <= 1'b0;
      r_ne_pulse <= w_empty && w_wr;

      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_rx_ack <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Hold off until the engine drops rxrdy so one byte is taken once.
          if (!rxrdy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (clr) begin
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_count      <= '0;
        r_ovf_sticky <= 1'b0;
      end else begin
        if (w_ovf) begin
          r_ovf_sticky <= 1'b1;
        end
        if (w_wr) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_rd) begin
          r_rptr <= r_rptr + AW'(1);
        end
        case ({w_wr, w_rd})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign rx_ack     = r_rx_ack;
  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_count;
  assign ovf_sticky = r_ovf_sticky;
  assign ne_pulse   = r_ne_pulse;
  assign dout       = w_empty ? 8'h00 : w_head[7:0];
  assign dout_err   = w_empty ? 3'b000 : w_head[10:8];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_fifo
// Purpose : Directed self-checking bench for uart_rx_fifo.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxrdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] rx_err = 3'b000;
  logic       rx_ack;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] dout;
  logic [2:0] dout_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovf_sticky;
  logic       ne_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int ne_cnt = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .rxrdy(rxrdy), .rx_data(rx_data),
    .rx_err(rx_err), .rx_ack(rx_ack), .rd(rd), .clr(clr), .dout(dout),
    .dout_err(dout_err), .empty(empty), .full(full), .count(count),
    .ovf_sticky(ovf_sticky), .ne_pulse(ne_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_ack) ack_cnt++;
    if (ne_pulse) ne_cnt++;
  end

  // Present a byte, hold rxrdy until the ack appears, then release it.
  task automatic send_byte(input logic [7:0] d, input logic [2:0] e);
    bit got;
    got = 0;
    @(negedge clk);
    rxrdy = 1'b1; rx_data = d; rx_err = e;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk); #1;
      if (rx_ack) got = 1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: no rx_ack for byte %h", d);
    end
    @(negedge clk);
    rxrdy = 1'b0;
    @(posedge clk); #1;
  endtask

  // Capture the head at a negedge, then strobe rd for one cycle.
  task automatic pop_byte(output logic [7:0] d, output logic [2:0] e);
    @(negedge clk);
    d = dout; e = dout_err;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rxrdy = 1'b1; rx_data = 8'hAA; rx_err = 3'b111;
    @(posedge clk); #1;
    n_cmp++;
    if (rx_ack !== 1'b1) begin n_err++; $display("FAIL rst_pre_ack: got %b want 1", rx_ack); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rx_ack, empty, full, count, ovf_sticky, ne_pulse} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_flags: ack=%b empty=%b full=%b count=%0d ovf=%b ne=%b want 0 1 0 0 0 0",
               rx_ack, empty, full, count, ovf_sticky, ne_pulse);
    end
    n_cmp++;
    if ({dout, dout_err} !== 11'h000) begin
      n_err++; $display("FAIL rst_dout: got %h/%b want 00/000", dout, dout_err);
    end
    rxrdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int a0, n0;
    a0 = ack_cnt; n0 = ne_cnt;
    send_byte(8'h5A, 3'b010);
    n_cmp++;
    if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL single_ack: got %0d pulses want 1", ack_cnt - a0); end
    n_cmp++;
    if (ne_cnt - n0 !== 1) begin n_err++; $display("FAIL single_ne: got %0d pulses want 1", ne_cnt - n0); end
    n_cmp++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL single_count: got %0d empty=%b want 1 empty=0", count, empty);
    end
    n_cmp++;
    if (dout !== 8'h5A || dout_err !== 3'b010) begin
      n_err++; $display("FAIL single_dout: got %h/%b want 5a/010", dout, dout_err);
    end
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || dout !== 8'h00 || count !== 5'd0) begin
      n_err++; $display("FAIL single_pop: empty=%b dout=%h count=%0d want 1 00 0", empty, dout, count);
    end
    // Read strobe while empty must be ignored.
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL empty_rd: count=%0d empty=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_fill();
    int a0;
    bit got;
    logic [7:0] d;
    logic [2:0] e;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 3'b000);
    n_cmp++;
    if (count !== 5'd16 || full !== 1'b1 || dout !== 8'h00) begin
      n_err++; $display("FAIL fill_full: count=%0d full=%b dout=%h want 16 1 00", count, full, dout);
    end
    a0 = ack_cnt;
    @(negedge clk);
    rxrdy = 1'b1; rx_data = 8'h10; rx_err = 3'b000;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (ack_cnt != a0 || ovf_sticky !== 1'b1 || count !== 5'd16) begin
      n_err++; $display("FAIL fill_bp: acks=%0d ovf=%b count=%0d want 0 1 16", ack_cnt - a0, ovf_sticky, count);
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (rx_ack) got = 1;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL fill_resume: no rx_ack after pop"); end
    @(negedge clk); rxrdy = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h01 || count !== 5'd16) begin
      n_err++; $display("FAIL fill_head: dout=%h count=%0d want 01 16", dout, count);
    end
    for (int i = 1; i <= 16; i++) begin
      pop_byte(d, e);
      n_cmp++;
      if (d !== 8'(i)) begin n_err++; $display("FAIL fill_drain: got %h want %h", d, 8'(i)); end
    end
    n_cmp++;
    if (empty !== 1'b1 || ovf_sticky !== 1'b1) begin
      n_err++; $display("FAIL fill_end: empty=%b ovf=%b want 1 1", empty, ovf_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [2:0] e;
    for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 3'b001);
    @(negedge clk);
    rxrdy = 1'b1; rx_data = 8'h25; rx_err = 3'b001; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    n_cmp++;
    if (rx_ack !== 1'b1 || count !== 5'd5) begin
      n_err++; $display("FAIL simul_count: ack=%b count=%0d want 1 5", rx_ack, count);
    end
    rxrdy = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dout !== 8'h21) begin n_err++; $display("FAIL simul_head: got %h want 21", dout); end
    for (int i = 1; i <= 5; i++) begin
      pop_byte(d, e);
      n_cmp++;
      if (d !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL simul_order: got %h want %h", d, 8'h20 + 8'(i)); end
    end
    n_cmp++;
    if (empty !== 1'b1) begin n_err++; $display("FAIL simul_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic [2:0] e;
    for (int i = 0; i < 40; i++) begin
      send_byte(8'h40 + 8'(i), 3'(i));
      pop_byte(d, e);
      n_cmp++;
      if (d !== 8'h40 + 8'(i) || e !== 3'(i)) begin
        n_err++; $display("FAIL wrap_data: got %h/%b want %h/%b", d, e, 8'h40 + 8'(i), 3'(i));
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_err++; $display("FAIL wrap_empty: empty=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_flush();
    int a0;
    logic [7:0] d;
    logic [2:0] e;
    for (int i = 0; i < 7; i++) send_byte(8'h80 + 8'(i), 3'b000);
    n_cmp++;
    if (count !== 5'd7 || ovf_sticky !== 1'b1) begin
      n_err++; $display("FAIL flush_pre: count=%0d ovf=%b want 7 1", count, ovf_sticky);
    end
    a0 = ack_cnt;
    @(negedge clk);
    rxrdy = 1'b1; rx_data = 8'h99; rx_err = 3'b100; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; rxrdy = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL flush_ack: got %0d pulses want 1", ack_cnt - a0); end
    n_cmp++;
    if (count !== 5'd0 || ovf_sticky !== 1'b0 || empty !== 1'b1 || dout !== 8'h00) begin
      n_err++; $display("FAIL flush_state: count=%0d ovf=%b empty=%b dout=%h want 0 0 1 00",
                        count, ovf_sticky, empty, dout);
    end
    send_byte(8'h77, 3'b101);
    n_cmp++;
    if (count !== 5'd1 || dout !== 8'h77 || dout_err !== 3'b101) begin
      n_err++; $display("FAIL flush_next: count=%0d dout=%h/%b want 1 77/101", count, dout, dout_err);
    end
    pop_byte(d, e);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
